amp_power_sequencer: RTL and testbench
======================================

// Module: amp_power_sequencer
// PURPOSE
//  Sequences the external class-D amplifier around the S/PDIF-to-I2S/PWM datapath. It drives amp_nenable and amp_mute,
//  and pushes a fixed register-config table to the amp through the amp-side I2C master (req/ack).
//  Power-up and unmute happen only after the decoder reports audio lock. Lock loss ramps down click-free: mute, then disable.
// PARAMETERS
//  T_ENABLE_CYC  4096  clk cycles from amp_nenable falling to the first config write
//  T_SETTLE_CYC  2048  clk cycles from last config ack to amp_mute release
//  T_MUTE_CYC    1024  clk cycles amp_mute is held before amp_nenable rises on lock loss
//  N_CFG         4     number of {reg_addr,reg_data} entries in amp_cfg_rom (1..16)
//  MAX_RETRY     2     re-attempts of one config entry after i2c_err, before FAULT
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  audio_locked  in   1  S/PDIF decoder lock status (level)
//  force_mute    in   1  host mute request (level)
//  fault_clr     in   1  one-cycle pulse; leaves FAULT
//  i2c_req       out  1  write request to amp I2C master
//  i2c_addr      out  8  amp register address; stable while i2c_req=1
//  i2c_data      out  8  amp register data; stable while i2c_req=1
//  i2c_ack       in   1  one-cycle completion pulse from I2C master
//  i2c_err       in   1  valid only with i2c_ack; 1 = NACK or bus error
//  amp_nenable   out  1  amp enable, active low
//  amp_mute      out  1  amp mute, active high
//  seq_state     out  3  current FSM state code (debug/status)
//  fault         out  1  sticky config-failure flag
// BEHAVIOUR
//  Reset values: amp_nenable=1, amp_mute=1, i2c_req=0, i2c_addr=0, i2c_data=0, fault=0, state=OFF.
//  All outputs are registered; each changes in the same edge as the state transition that causes it.
//  One down-counter, $clog2(max T_*) bits wide, is shared by all wait states. It loads T_x-1 on entry, so a wait lasts exactly T_x cycles.
//  OFF(0): nenable=1, mute=1. When audio_locked=1 -> EN_WAIT; nenable<=0.
//  EN_WAIT(1): at count 0 -> CFG. idx<=0, retry<=0, i2c_req<=1, addr/data<=rom[0].
//  CFG(2): i2c_req stays high until the ack cycle and drops on the following edge.
//    - ack & !err: idx<N_CFG-1 -> idx++, issue rom[idx+1] the next cycle (one idle cycle between reqs); idx==N_CFG-1 -> SETTLE.
//    - ack & err: retry<MAX_RETRY -> retry++, reissue same entry; else -> FAULT.
//    - retry clears on every successful entry.
//  SETTLE(3): at count 0 -> RUN.
//  RUN(4): amp_mute = force_mute, registered, 1-cycle latency. !audio_locked -> MUTE_WAIT; mute<=1.
//  MUTE_WAIT(5): mute=1. At count 0 -> OFF; nenable<=1. Lock return during MUTE_WAIT does not abort; OFF re-enters EN_WAIT next cycle.
//  FAULT(6): nenable=1, mute=1, fault=1, req=0. fault_clr -> OFF with fault<=0. fault_clr in any other state is ignored.
//  Lock loss before RUN (EN_WAIT, SETTLE) -> OFF immediately; nenable<=1; mute never released.
//  Lock loss in CFG: the outstanding req is never withdrawn. Wait for ack (err ignored), then -> OFF.
//  force_mute never changes state and only gates mute in RUN.
//  Simultaneous events:
//    - In RUN, lock loss beats force_mute deassert.
//    - In CFG, ack and lock loss in the same cycle -> OFF.
//    - fault_clr together with audio_locked -> OFF first; EN_WAIT follows the next cycle.
//  Reset mid-sequence: the synchronous reset forces reset values at the next edge; any I2C transaction in flight is abandoned.
// STRUCTURE
//  toi2s_pkg: seq_state_t encoding (OFF..FAULT, 3 bits), cfg entry width (16 = addr8+data8), amp register address constants.
//  amp_cfg_rom: combinational ROM, input idx[3:0], output {addr,data}; N_CFG entries; the table lives here only.
//  amp_power_sequencer holds the FSM, counter, idx/retry registers, output registers.
// TESTING (bench: T_ENABLE_CYC=16, T_SETTLE_CYC=8, T_MUTE_CYC=4, N_CFG=4, ack 3 cycles after req)
//  1 lock at cycle 10 -> nenable=0 at 11; first req at 27 with rom[0]; 4 writes in order; mute=0 8 cycles after 4th ack; state=RUN.
//  2 RUN, drop lock -> mute=1 next edge; nenable=1 exactly 4 cycles later; state OFF; relock restarts full sequence.
//  3 entry 2 acked with err twice then ok -> 3 reqs for rom[2], no fault; err 3 times -> FAULT, fault=1; fault_clr -> OFF, fault=0.
//  4 drop lock while req for rom[1] outstanding -> req held until ack; OFF on ack edge+1; mute stays 1 throughout.
//  5 force_mute toggled in RUN -> amp_mute follows with 1 cycle latency; force_mute during CFG leaves sequence unchanged.
//  6 reset asserted mid-SETTLE and mid-CFG -> all outputs at reset values next edge; checker: addr/data stable while req=1.

Source files
------------

// File: rtl/toi2s_pkg.sv
// Shared types for the S/PDIF-to-I2S/PWM amp control path: sequencer state
// encoding, amp config entry layout and amp register map.
package toi2s_pkg;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_EN_WAIT   = 3'd1,
    S_CFG       = 3'd2,
    S_SETTLE    = 3'd3,
    S_RUN       = 3'd4,
    S_MUTE_WAIT = 3'd5,
    S_FAULT     = 3'd6
  } seq_state_t;

  localparam int CFG_W     = 16;
  localparam int CFG_IDX_W = 4;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam logic [7:0] REG_PWR_CTRL = 8'h01;
  localparam logic [7:0] REG_CLK_CFG  = 8'h02;
  localparam logic [7:0] REG_I2S_FMT  = 8'h03;
  localparam logic [7:0] REG_VOLUME   = 8'h04;
  localparam logic [7:0] REG_PROT     = 8'h05;
  localparam logic [7:0] REG_EQ_BASE  = 8'h10;
  localparam logic [7:0] REG_PWM_CFG  = 8'h20;
  localparam logic [7:0] REG_DC_DET   = 8'h21;

  function automatic cfg_entry_t mk_cfg(input logic [7:0] a, input logic [7:0] d);
    cfg_entry_t e;
    e.addr = a;
    e.data = d;
    return e;
  endfunction

endpackage

// File: rtl/amp_cfg_rom.sv
// Amp register init table, written in order by the power sequencer.
// Entries at or beyond N_CFG read back as zero.
module amp_cfg_rom
  import toi2s_pkg::*;
#(
  parameter int N_CFG = 4
) (
  input  logic [CFG_IDX_W-1:0] idx,
  output cfg_entry_t           entry
);

  cfg_entry_t tbl;

  always_comb begin
    tbl = '0;
    case (idx)
      4'd0:  tbl = mk_cfg(REG_PWR_CTRL,      8'h80);
      4'd1:  tbl = mk_cfg(REG_CLK_CFG,       8'h11);
      4'd2:  tbl = mk_cfg(REG_I2S_FMT,       8'h02);
      4'd3:  tbl = mk_cfg(REG_VOLUME,        8'h60);
      4'd4:  tbl = mk_cfg(REG_PROT,          8'h0f);
      4'd5:  tbl = mk_cfg(REG_PWM_CFG,       8'h03);
      4'd6:  tbl = mk_cfg(REG_DC_DET,        8'h01);
      4'd7:  tbl = mk_cfg(REG_EQ_BASE,       8'h40);
      4'd8:  tbl = mk_cfg(REG_EQ_BASE + 8'd1, 8'h40);
      4'd9:  tbl = mk_cfg(REG_EQ_BASE + 8'd2, 8'h40);
      4'd10: tbl = mk_cfg(REG_EQ_BASE + 8'd3, 8'h40);
      4'd11: tbl = mk_cfg(REG_EQ_BASE + 8'd4, 8'h40);
      4'd12: tbl = mk_cfg(REG_EQ_BASE + 8'd5, 8'h40);
      4'd13: tbl = mk_cfg(REG_EQ_BASE + 8'd6, 8'h40);
      4'd14: tbl = mk_cfg(REG_EQ_BASE + 8'd7, 8'h40);
      4'd15: tbl = mk_cfg(REG_PWR_CTRL,      8'h81);
      default: tbl = '0;
    endcase
  end

  assign entry = (int'(idx) < N_CFG) ? tbl : '0;

endmodule

// File: rtl/amp_power_sequencer.sv
// Class-D amp power/mute sequencer: enables the amp on audio lock, pushes the
// config table over I2C, unmutes after settle, and ramps down mute-then-disable.
module amp_power_sequencer
  import toi2s_pkg::*;
#(
  parameter int T_ENABLE_CYC = 4096,
  parameter int T_SETTLE_CYC = 2048,
  parameter int T_MUTE_CYC   = 1024,
  parameter int N_CFG        = 4,
  parameter int MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       audio_locked,
  input  logic       force_mute,
  input  logic       fault_clr,
  output logic       i2c_req,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_data,
  input  logic       i2c_ack,
  input  logic       i2c_err,
  output logic       amp_nenable,
  output logic       amp_mute,
  output logic [2:0] seq_state,
  output logic       fault
);

  localparam int T_MAX0 = (T_ENABLE_CYC > T_SETTLE_CYC) ? T_ENABLE_CYC : T_SETTLE_CYC;
  localparam int T_MAX  = (T_MAX0 > T_MUTE_CYC) ? T_MAX0 : T_MUTE_CYC;
  localparam int CNT_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]     LD_ENABLE = CNT_W'(T_ENABLE_CYC - 1);
  localparam logic [CNT_W-1:0]     LD_SETTLE = CNT_W'(T_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]     LD_MUTE   = CNT_W'(T_MUTE_CYC - 1);
  localparam logic [CFG_IDX_W-1:0] LAST_IDX  = CFG_IDX_W'(N_CFG - 1);

  seq_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic [CFG_IDX_W-1:0] idx;
  logic [RTY_W-1:0]     retry;
  logic                 abort;
  cfg_entry_t           rom_q;

  amp_cfg_rom #(.N_CFG(N_CFG)) u_rom (
    .idx   (idx),
    .entry (rom_q)
  );

  assign seq_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_OFF;
      cnt         <= '0;
      idx         <= '0;
      retry       <= '0;
      abort       <= 1'b0;
      i2c_req     <= 1'b0;
      i2c_addr    <= '0;
      i2c_data    <= '0;
      amp_nenable <= 1'b1;
      amp_mute    <= 1'b1;
      fault       <= 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          amp_nenable <= 1'b1;
          amp_mute    <= 1'b1;
          if (audio_locked) begin
            state       <= S_EN_WAIT;
            amp_nenable <= 1'b0;
            cnt         <= LD_ENABLE;
            idx         <= '0;
          end
        end

        S_EN_WAIT: begin
          if (!audio_locked) begin
            state       <= S_OFF;
            amp_nenable <= 1'b1;
          end else if (cnt == '0) begin
            state    <= S_CFG;
            idx      <= '0;
            retry    <= '0;
            abort    <= 1'b0;
            i2c_req  <= 1'b1;
            i2c_addr <= rom_q.addr;
            i2c_data <= rom_q.data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // A request on the bus is never withdrawn: a lock loss seen while it is
        // outstanding is remembered and acted on at the ack.
        S_CFG: begin
          if (i2c_req) begin
            if (!audio_locked) abort <= 1'b1;
            if (i2c_ack) begin
              i2c_req <= 1'b0;
              if (abort || !audio_locked) begin
                state       <= S_OFF;
                amp_nenable <= 1'b1;
              end else if (i2c_err) begin
                if (int'(retry) < MAX_RETRY) begin
                  retry <= retry + 1'b1;
                end else begin
                  state       <= S_FAULT;
                  fault       <= 1'b1;
                  amp_nenable <= 1'b1;
                end
              end else if (idx == LAST_IDX) begin
                state <= S_SETTLE;
                cnt   <= LD_SETTLE;
                retry <= '0;
              end else begin
                idx   <= idx + 1'b1;
                retry <= '0;
              end
            end
          end else if (!audio_locked) begin
            state       <= S_OFF;
            amp_nenable <= 1'b1;
          end else begin
            i2c_req  <= 1'b1;
            i2c_addr <= rom_q.addr;
            i2c_data <= rom_q.data;
          end
        end

        S_SETTLE: begin
          if (!audio_locked) begin
            state       <= S_OFF;
            amp_nenable <= 1'b1;
          end else if (cnt == '0) begin
            state    <= S_RUN;
            amp_mute <= force_mute;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RUN: begin
          if (!audio_locked) begin
            state    <= S_MUTE_WAIT;
            amp_mute <= 1'b1;
            cnt      <= LD_MUTE;
          end else begin
            amp_mute <= force_mute;
          end
        end

        S_MUTE_WAIT: begin
          amp_mute <= 1'b1;
          if (cnt == '0) begin
            state       <= S_OFF;
            amp_nenable <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_FAULT: begin
          amp_nenable <= 1'b1;
          amp_mute    <= 1'b1;
          i2c_req     <= 1'b0;
          if (fault_clr) begin
            state <= S_OFF;
            fault <= 1'b0;
          end
        end

        default: begin
          state       <= S_OFF;
          i2c_req     <= 1'b0;
          amp_nenable <= 1'b1;
          amp_mute    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amp_power_sequencer.sv
// Directed bench for amp_power_sequencer with short timing parameters and an
// I2C master model that acks 3 cycles after each request.
module tb_amp_power_sequencer;

  localparam logic [2:0] ST_OFF = 3'd0, ST_EN_WAIT = 3'd1, ST_CFG = 3'd2,
                         ST_SETTLE = 3'd3, ST_RUN = 3'd4, ST_MUTE_WAIT = 3'd5,
                         ST_FAULT = 3'd6;

  logic       clk = 1'b0;
  logic       reset;
  logic       audio_locked, force_mute, fault_clr;
  logic       i2c_req, i2c_ack, i2c_err;
  logic [7:0] i2c_addr, i2c_data;
  logic       amp_nenable, amp_mute, fault;
  logic [2:0] seq_state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] exp_addr [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [7:0] exp_data [4] = '{8'h80, 8'h11, 8'h02, 8'h60};

  logic [15:0] log_q [$];
  bit          err_q [$];
  int          stable_err = 0;
  int          ack_edge   = 0;
  int          age        = 0;
  logic [7:0]  lat_addr, lat_data;

  amp_power_sequencer #(
    .T_ENABLE_CYC(16), .T_SETTLE_CYC(8), .T_MUTE_CYC(4), .N_CFG(4), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset(reset), .audio_locked(audio_locked), .force_mute(force_mute),
    .fault_clr(fault_clr), .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_data(i2c_data),
    .i2c_ack(i2c_ack), .i2c_err(i2c_err), .amp_nenable(amp_nenable), .amp_mute(amp_mute),
    .seq_state(seq_state), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // I2C master model: ack (with optional queued err) sampled 3 edges after req rises
  initial begin
    i2c_ack = 1'b0;
    i2c_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (i2c_ack) begin
        i2c_ack = 1'b0;
        i2c_err = 1'b0;
        age     = 0;
      end else if (i2c_req) begin
        if (age == 0) begin
          lat_addr = i2c_addr;
          lat_data = i2c_data;
        end else if (i2c_addr !== lat_addr || i2c_data !== lat_data) begin
          stable_err++;
        end
        age++;
        if (age == 3) begin
          i2c_ack  = 1'b1;
          i2c_err  = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
          log_q.push_back({lat_addr, lat_data});
          ack_edge = cyc + 1;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    int n = 0;
    while (seq_state !== s && n < budget) begin
      tick();
      n++;
    end
    ok = (seq_state === s);
  endtask

  task automatic test_reset();
    reset = 1'b1; audio_locked = 1'b0; force_mute = 1'b0; fault_clr = 1'b0;
    repeat (3) tick();
    tests++;
    if ({amp_nenable, amp_mute, i2c_req, i2c_addr, i2c_data, fault, seq_state} !==
        {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ST_OFF}) begin
      fails++;
      $display("FAIL reset_values: nen=%b mute=%b req=%b addr=%h data=%h fault=%b st=%0d, want 1 1 0 00 00 0 0",
               amp_nenable, amp_mute, i2c_req, i2c_addr, i2c_data, fault, seq_state);
    end
    reset = 1'b0;
    repeat (2) tick();
    tests++;
    if (seq_state !== ST_OFF || amp_nenable !== 1'b1) begin
      fails++;
      $display("FAIL idle_no_lock: st=%0d nen=%b, want 0 1", seq_state, amp_nenable);
    end
  endtask

  task automatic test_power_up();
    int t_en;
    bit ok;
    log_q.delete(); err_q.delete();
    audio_locked = 1'b1;
    tick();
    t_en = cyc;
    tests++;
    if (amp_nenable !== 1'b0 || seq_state !== ST_EN_WAIT || amp_mute !== 1'b1) begin
      fails++;
      $display("FAIL nenable_fall: nen=%b st=%0d mute=%b, want 0 1 1", amp_nenable, seq_state, amp_mute);
    end
    repeat (15) tick();
    tests++;
    if (i2c_req !== 1'b0) begin
      fails++;
      $display("FAIL req_early: req=%b at enable+15, want 0", i2c_req);
    end
    tick();
    tests++;
    if (i2c_req !== 1'b1 || i2c_addr !== 8'h01 || i2c_data !== 8'h80 || seq_state !== ST_CFG) begin
      fails++;
      $display("FAIL first_req: req=%b addr=%h data=%h st=%0d, want 1 01 80 2",
               i2c_req, i2c_addr, i2c_data, seq_state);
    end
    wait_state(ST_RUN, 100, ok);
    tests++;
    if (!ok || cyc != t_en + 39 || amp_mute !== 1'b0 || cyc != ack_edge + 8) begin
      fails++;
      $display("FAIL run_entry: ok=%b at=%0d mute=%b last_ack=%0d, want 1 %0d 0 %0d",
               ok, cyc - t_en, amp_mute, ack_edge, 39, cyc - 8);
    end
    tests++;
    if (log_q.size() != 4) begin
      fails++;
      $display("FAIL cfg_count: got %0d writes, want 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (log_q[i] !== {exp_addr[i], exp_data[i]}) begin
          fails++;
          $display("FAIL cfg_order[%0d]: got %h, want %h%h", i, log_q[i], exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_lock_loss_run();
    bit ok;
    audio_locked = 1'b0;
    tick();
    tests++;
    if (amp_mute !== 1'b1 || amp_nenable !== 1'b0 || seq_state !== ST_MUTE_WAIT) begin
      fails++;
      $display("FAIL mute_first: mute=%b nen=%b st=%0d, want 1 0 5", amp_mute, amp_nenable, seq_state);
    end
    repeat (3) tick();
    tests++;
    if (amp_nenable !== 1'b0) begin
      fails++;
      $display("FAIL mute_hold: nen=%b 3 cycles after mute, want 0", amp_nenable);
    end
    tick();
    tests++;
    if (amp_nenable !== 1'b1 || seq_state !== ST_OFF || amp_mute !== 1'b1) begin
      fails++;
      $display("FAIL disable_after_mute: nen=%b st=%0d mute=%b, want 1 0 1", amp_nenable, seq_state, amp_mute);
    end
    log_q.delete();
    audio_locked = 1'b1;
    wait_state(ST_RUN, 100, ok);
    tests++;
    if (!ok || log_q.size() != 4 || amp_mute !== 1'b0) begin
      fails++;
      $display("FAIL relock: ok=%b writes=%0d mute=%b, want 1 4 0", ok, log_q.size(), amp_mute);
    end
  endtask

  task automatic test_retry_fault();
    bit ok;
    int n3;
    audio_locked = 1'b0;
    wait_state(ST_OFF, 20, ok);
    log_q.delete();
    err_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    audio_locked = 1'b1;
    wait_state(ST_RUN, 200, ok);
    n3 = 0;
    foreach (log_q[i]) if (log_q[i][15:8] == 8'h03) n3++;
    tests++;
    if (!ok || fault !== 1'b0 || n3 != 3 || log_q.size() != 6) begin
      fails++;
      $display("FAIL retry_ok: ok=%b fault=%b rom2_reqs=%0d writes=%0d, want 1 0 3 6",
               ok, fault, n3, log_q.size());
    end
    audio_locked = 1'b0;
    wait_state(ST_OFF, 20, ok);
    log_q.delete();
    err_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    audio_locked = 1'b1;
    wait_state(ST_FAULT, 200, ok);
    tests++;
    if (!ok || fault !== 1'b1 || amp_nenable !== 1'b1 || amp_mute !== 1'b1 ||
        i2c_req !== 1'b0 || log_q.size() != 5) begin
      fails++;
      $display("FAIL fault_entry: ok=%b fault=%b nen=%b mute=%b req=%b writes=%0d, want 1 1 1 1 0 5",
               ok, fault, amp_nenable, amp_mute, i2c_req, log_q.size());
    end
    repeat (5) tick();
    tests++;
    if (seq_state !== ST_FAULT || fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_sticky: st=%0d fault=%b, want 6 1", seq_state, fault);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tests++;
    if (seq_state !== ST_OFF || fault !== 1'b0) begin
      fails++;
      $display("FAIL fault_clr: st=%0d fault=%b, want 0 0", seq_state, fault);
    end
    tick();
    tests++;
    if (seq_state !== ST_EN_WAIT || amp_nenable !== 1'b0) begin
      fails++;
      $display("FAIL clr_then_enable: st=%0d nen=%b, want 1 0", seq_state, amp_nenable);
    end
    audio_locked = 1'b0;
    tick();
    tests++;
    if (seq_state !== ST_OFF || amp_nenable !== 1'b1) begin
      fails++;
      $display("FAIL en_wait_lock_loss: st=%0d nen=%b, want 0 1", seq_state, amp_nenable);
    end
  endtask

  task automatic test_lock_loss_cfg();
    int n = 0;
    log_q.delete();
    audio_locked = 1'b1;
    while (!(i2c_req === 1'b1 && i2c_addr === 8'h02) && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL find_req1: no request for rom[1] within %0d cycles, want one", n);
    end
    audio_locked = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      tests++;
      if (i2c_req !== 1'b1 || seq_state !== ST_CFG || amp_mute !== 1'b1 || i2c_addr !== 8'h02) begin
        fails++;
        $display("FAIL req_held[%0d]: req=%b st=%0d mute=%b addr=%h, want 1 2 1 02",
                 k, i2c_req, seq_state, amp_mute, i2c_addr);
      end
    end
    tick();
    tests++;
    if (seq_state !== ST_OFF || i2c_req !== 1'b0 || amp_nenable !== 1'b1 || amp_mute !== 1'b1) begin
      fails++;
      $display("FAIL off_on_ack: st=%0d req=%b nen=%b mute=%b, want 0 0 1 1",
               seq_state, i2c_req, amp_nenable, amp_mute);
    end
  endtask

  task automatic test_force_mute();
    bit ok;
    int t_cfg;
    audio_locked = 1'b1;
    wait_state(ST_RUN, 100, ok);
    force_mute = 1'b1;
    tests++;
    if (!ok || amp_mute !== 1'b0) begin
      fails++;
      $display("FAIL fm_latency0: ok=%b mute=%b before edge, want 1 0", ok, amp_mute);
    end
    tick();
    tests++;
    if (amp_mute !== 1'b1 || seq_state !== ST_RUN) begin
      fails++;
      $display("FAIL fm_assert: mute=%b st=%0d, want 1 4", amp_mute, seq_state);
    end
    force_mute = 1'b0;
    tick();
    tests++;
    if (amp_mute !== 1'b0) begin
      fails++;
      $display("FAIL fm_release: mute=%b, want 0", amp_mute);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tests++;
    if (seq_state !== ST_RUN || fault !== 1'b0) begin
      fails++;
      $display("FAIL clr_ignored: st=%0d fault=%b, want 4 0", seq_state, fault);
    end
    audio_locked = 1'b0;
    wait_state(ST_OFF, 20, ok);
    log_q.delete();
    audio_locked = 1'b1;
    wait_state(ST_CFG, 40, ok);
    t_cfg = cyc;
    force_mute = 1'b1;
    repeat (5) tick();
    tests++;
    if (seq_state !== ST_CFG || amp_mute !== 1'b1 || amp_nenable !== 1'b0) begin
      fails++;
      $display("FAIL fm_in_cfg: st=%0d mute=%b nen=%b, want 2 1 0", seq_state, amp_mute, amp_nenable);
    end
    force_mute = 1'b0;
    wait_state(ST_RUN, 100, ok);
    tests++;
    if (!ok || cyc != t_cfg + 23 || amp_mute !== 1'b0 || log_q.size() != 4) begin
      fails++;
      $display("FAIL fm_cfg_timing: ok=%b run_at=%0d mute=%b writes=%0d, want 1 23 0 4",
               ok, cyc - t_cfg, amp_mute, log_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    audio_locked = 1'b0;
    wait_state(ST_OFF, 20, ok);
    audio_locked = 1'b1;
    wait_state(ST_SETTLE, 100, ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (!ok || {amp_nenable, amp_mute, i2c_req, i2c_addr, i2c_data, fault, seq_state} !==
        {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ST_OFF}) begin
      fails++;
      $display("FAIL reset_settle: ok=%b nen=%b mute=%b req=%b addr=%h data=%h st=%0d, want 1 1 1 0 00 00 0",
               ok, amp_nenable, amp_mute, i2c_req, i2c_addr, i2c_data, seq_state);
    end
    wait_state(ST_CFG, 40, ok);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (!ok || {amp_nenable, amp_mute, i2c_req, i2c_addr, i2c_data, fault, seq_state} !==
        {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, ST_OFF}) begin
      fails++;
      $display("FAIL reset_cfg: ok=%b nen=%b mute=%b req=%b addr=%h data=%h st=%0d, want 1 1 1 0 00 00 0",
               ok, amp_nenable, amp_mute, i2c_req, i2c_addr, i2c_data, seq_state);
    end
    log_q.delete();
    wait_state(ST_RUN, 200, ok);
    tests++;
    if (!ok || log_q.size() != 4) begin
      fails++;
      $display("FAIL reset_recover: ok=%b writes=%0d, want 1 4", ok, log_q.size());
    end
    tests++;
    if (stable_err != 0) begin
      fails++;
      $display("FAIL addr_data_stable: %0d changes while req=1, want 0", stable_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss_run();
    test_retry_fault();
    test_lock_loss_cfg();
    test_force_mute();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
